// File: rtl/mul_pkg.sv
// ============================================================================
// mul_pkg : shared state encoding and default width for the iterative multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

package mul_pkg;
   localparam int WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

`default_nettype wire

// File: rtl/mul_if.sv
// ============================================================================
// mul_if : launch/operand/writeback bundle between execute stage and multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

interface mul_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             accumulate;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] acc_in;
   logic [3:0]       dest_in;
   logic             flush;
   logic [WIDTH-1:0] result;
   logic             flag_n;
   logic             flag_z;
   logic [3:0]       dest_out;
   logic             write_enable;
   logic             busy;

   modport master (
      output start, accumulate, op_a, op_b, acc_in, dest_in, flush,
      input  result, flag_n, flag_z, dest_out, write_enable, busy
   );

   modport slave (
      input  start, accumulate, op_a, op_b, acc_in, dest_in, flush,
      output result, flag_n, flag_z, dest_out, write_enable, busy
   );
endinterface

`default_nettype wire

// File: rtl/mul_datapath.sv
// ============================================================================
// mul_datapath : shift-add registers (multiplicand, multiplier, product, count)
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_datapath
   import mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int CNT_W = 6
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             i_load,
   input  wire logic             i_step,
   input  wire logic             i_accumulate,
   input  wire logic [WIDTH-1:0] i_op_a,
   input  wire logic [WIDTH-1:0] i_op_b,
   input  wire logic [WIDTH-1:0] i_acc_in,
   output logic      [WIDTH-1:0] o_prod_next,
   output logic                  o_last_iter
);
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_prod;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] w_mplier_next;

   assign w_mplier_next = r_mplier >> 1;
   assign o_prod_next   = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
   // Early exit once no multiplier bits remain; the count bound covers bit WIDTH-1.
   assign o_last_iter   = (w_mplier_next == '0) || (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
      end else if (i_load) begin
         r_mcand  <= i_op_a;
         r_mplier <= i_op_b;
         r_prod   <= i_accumulate ? i_acc_in : '0;
         r_cnt    <= '0;
      end else if (i_step) begin
         r_prod   <= o_prod_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= w_mplier_next;
         r_cnt    <= r_cnt + 1'b1;
      end
   end
endmodule

`default_nettype wire

// File: rtl/iterative_mul_unit.sv
// ============================================================================
// iterative_mul_unit : multi-cycle MUL/MLA with early termination and writeback
// Rev 1.0
// ============================================================================
`default_nettype none

module iterative_mul_unit
   import mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int CNT_W = 6
) (
   input  wire logic clk,
   input  wire logic reset,
   mul_if.slave      bus
);
   state_t           r_state;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_dest;
   logic             r_we;
   logic             r_busy;
   logic             w_load;
   logic             w_step;
   logic             w_last_iter;
   logic [WIDTH-1:0] w_prod_next;

   assign w_load = (r_state == IDLE) && bus.start && !bus.flush;
   assign w_step = (r_state == RUN) && !bus.flush;

   mul_datapath #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_datapath (
      .clk          (clk),
      .reset        (reset),
      .i_load       (w_load),
      .i_step       (w_step),
      .i_accumulate (bus.accumulate),
      .i_op_a       (bus.op_a),
      .i_op_b       (bus.op_b),
      .i_acc_in     (bus.acc_in),
      .o_prod_next  (w_prod_next),
      .o_last_iter  (w_last_iter)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_result <= '0;
         r_dest   <= '0;
         r_we     <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_we <= 1'b0;
               if (w_load) begin
                  r_state <= RUN;
                  r_busy  <= 1'b1;
                  r_dest  <= bus.dest_in;
               end
            end
            RUN: begin
               // Flush beats completion: the aborted result must never be written.
               if (bus.flush) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (w_last_iter) begin
                  r_state  <= DONE;
                  r_result <= w_prod_next;
                  r_we     <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_we    <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_we    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.result       = r_result;
   assign bus.flag_n       = r_result[WIDTH-1];
   assign bus.flag_z       = (r_result == '0);
   assign bus.dest_out     = r_dest;
   assign bus.write_enable = r_we;
   assign bus.busy         = r_busy;
endmodule

`default_nettype wire
